// File: rtl/mult_wb_if.sv
// Issue/result bundle between the operand source, the multiplier and the
// RegisterFile write port.
interface mult_wb_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic              signed_op;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [ADDR_W-1:0] dest_reg;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [ADDR_W-1:0] wb_reg;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_en;

    modport master (
        output start, signed_op, op_a, op_b, dest_reg,
        input  busy, done, hi, lo, wb_reg, wb_data, wb_en
    );

    modport slave (
        input  start, signed_op, op_a, op_b, dest_reg,
        output busy, done, hi, lo, wb_reg, wb_data, wb_en
    );
endinterface

// File: rtl/mult_wb_unit.sv
// Iterative shift-add multiplier producing a 2*WIDTH product in hi/lo and a
// RegisterFile write-back request for the low word.
module mult_wb_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic      clk,
    input logic      rst,
    mult_wb_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     acc;
    logic              neg;
    logic [CW-1:0]     cnt;

    logic              busy;
    logic              done;
    logic              wb_en;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  wb_data;
    logic [ADDR_W-1:0] wb_reg;

    logic              load_c;
    logic              step_c;
    logic              finish_c;
    logic              last_c;
    logic [WIDTH-1:0]  a_mag_c;
    logic [WIDTH-1:0]  b_mag_c;
    logic              neg_c;
    logic [PW-1:0]     product_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cnt reaching WIDTH means all iterations have been applied
    assign last_c = (cnt == CW'(WIDTH));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_c)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        case (state)
            IDLE:    load_c   = bus.start;
            RUN: begin
                step_c   = !last_c;
                finish_c = last_c;
            end
            default: ;
        endcase
    end

    // Operand magnitudes; the most negative value maps onto itself as unsigned
    always_comb begin
        a_mag_c = bus.op_a;
        b_mag_c = bus.op_b;
        neg_c   = 1'b0;
        if (bus.signed_op) begin
            if (bus.op_a[WIDTH-1]) a_mag_c = WIDTH'(~bus.op_a + WIDTH'(1));
            if (bus.op_b[WIDTH-1]) b_mag_c = WIDTH'(~bus.op_b + WIDTH'(1));
            neg_c = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
        end
    end

    assign product_c = neg ? PW'(~acc + PW'(1)) : acc;

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_en   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            wb_data <= '0;
            wb_reg  <= '0;
        end else begin
            busy  <= (state_nxt != IDLE);
            done  <= finish_c;
            wb_en <= finish_c && (wb_reg != '0);

            if (load_c) begin
                mcand  <= PW'(a_mag_c);
                mplier <= b_mag_c;
                acc    <= '0;
                neg    <= neg_c;
                cnt    <= '0;
                wb_reg <= bus.dest_reg;
            end

            if (step_c) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= {mcand[PW-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                cnt    <= cnt + CW'(1);
            end

            if (finish_c) begin
                hi      <= product_c[PW-1:WIDTH];
                lo      <= product_c[WIDTH-1:0];
                wb_data <= product_c[WIDTH-1:0];
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.wb_en   = wb_en;
    assign bus.hi      = hi;
    assign bus.lo      = lo;
    assign bus.wb_data = wb_data;
    assign bus.wb_reg  = wb_reg;
endmodule
